// File: rtl/lb_bram_bridge.sv
// Local-bus to BRAM bridge: parameter-decoded write/read channels, a fixed-latency
// read pipeline and saturating counters for accesses that hit no channel.
module lb_bram_bridge #(
    parameter int                          DATA_WIDTH    = 32,
    parameter int                          ADDR_WIDTH    = 24,
    parameter int                          AW_MAX        = 16,
    parameter int                          NWR           = 4,
    parameter int                          NRD           = 4,
    parameter logic [NWR*ADDR_WIDTH-1:0]   WR_BASE       = {24'h030000, 24'h020000, 24'h010000, 24'h000000},
    parameter logic [NWR*8-1:0]            WR_AW         = {8'd16, 8'd16, 8'd16, 8'd16},
    parameter logic [NRD*ADDR_WIDTH-1:0]   RD_BASE       = {24'h081000, 24'h080000, 24'h044000, 24'h040000},
    parameter logic [NRD*8-1:0]            RD_AW         = {8'd12, 8'd12, 8'd14, 8'd14},
    parameter int                          READDELAY     = 4,
    parameter logic [DATA_WIDTH-1:0]       DEFAULT_RDATA = 32'hdeadbeef
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       lb_wren,
    input  logic [ADDR_WIDTH-1:0]      lb_waddr,
    input  logic [DATA_WIDTH-1:0]      lb_wdata,
    input  logic                       lb_rden,
    input  logic [ADDR_WIDTH-1:0]      lb_raddr,
    input  logic                       lb_rdenlast,
    output logic [DATA_WIDTH-1:0]      lb_rdata,
    output logic                       lb_rvalid,
    output logic                       lb_rvalidlast,
    output logic [NWR-1:0]             wr_we,
    output logic [NWR*AW_MAX-1:0]      wr_addr,
    output logic [NWR*DATA_WIDTH-1:0]  wr_din,
    output logic [NRD*AW_MAX-1:0]      rd_addr,
    input  logic [NRD*DATA_WIDTH-1:0]  rd_dout,
    input  logic                       err_clr,
    output logic [15:0]                err_wr_cnt,
    output logic [15:0]                err_rd_cnt
);

    localparam int RSW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int NST = READDELAY + 2;

    logic [NWR-1:0]            w_wr_hit;
    logic [NWR-1:0]            w_wr_onehot;
    logic [NWR*AW_MAX-1:0]     w_wr_addr_nxt;
    logic [NRD-1:0]            w_rd_hit;
    logic [RSW-1:0]            w_rd_sel;
    logic                      w_rd_unmap;
    logic [NRD*AW_MAX-1:0]     w_rd_addr_nxt;
    logic [DATA_WIDTH-1:0]     w_rd_dout_arr [NRD];

    logic [NST-1:0]            r_vld_p;
    logic [NST-1:0]            r_last_p;
    logic [NST-1:0]            r_unmap_p;
    logic [RSW-1:0]            r_sel_p [NST];
    logic [DATA_WIDTH-1:0]     r_rdat_p;

    function automatic logic [15:0] err_next(input logic [15:0] cnt, input logic ev, input logic clr);
        if (clr)
            return {15'd0, ev};
        if (ev && (cnt != 16'hFFFF))
            return cnt + 16'd1;
        return cnt;
    endfunction

    // Window decode: a channel hits when the address bits above its window match its base.
    for (genvar k = 0; k < NWR; k++) begin : g_wr
        localparam int                    AW    = int'(WR_AW[k*8 +: 8]);
        localparam logic [ADDR_WIDTH-1:0] BASE  = WR_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] LMASK = ~({ADDR_WIDTH{1'b1}} << AW);
        if (AW == 0 || AW > AW_MAX) begin : g_aw_bad
            $error("lb_bram_bridge: write channel %0d window width %0d out of range", k, AW);
        end
        if ((BASE & LMASK) != '0) begin : g_base_bad
            $error("lb_bram_bridge: write channel %0d base not aligned to its window", k);
        end
        assign w_wr_hit[k] = ((lb_waddr ^ BASE) & ~LMASK) == '0;
        assign w_wr_addr_nxt[k*AW_MAX +: AW_MAX] = AW_MAX'(lb_waddr & LMASK);
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        localparam int                    AW    = int'(RD_AW[k*8 +: 8]);
        localparam logic [ADDR_WIDTH-1:0] BASE  = RD_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] LMASK = ~({ADDR_WIDTH{1'b1}} << AW);
        if (AW == 0 || AW > AW_MAX) begin : g_aw_bad
            $error("lb_bram_bridge: read channel %0d window width %0d out of range", k, AW);
        end
        if ((BASE & LMASK) != '0) begin : g_base_bad
            $error("lb_bram_bridge: read channel %0d base not aligned to its window", k);
        end
        assign w_rd_hit[k] = ((lb_raddr ^ BASE) & ~LMASK) == '0;
        assign w_rd_addr_nxt[k*AW_MAX +: AW_MAX] = AW_MAX'(lb_raddr & LMASK);
        assign w_rd_dout_arr[k] = rd_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Overlapping windows resolve to the lowest-index hit.
    assign w_wr_onehot = w_wr_hit & (~w_wr_hit + NWR'(1));
    assign w_rd_unmap  = ~|w_rd_hit;

    always_comb begin
        w_rd_sel = '0;
        for (int k = NRD - 1; k >= 0; k--)
            if (w_rd_hit[k])
                w_rd_sel = RSW'(k);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_we      <= '0;
            wr_addr    <= '0;
            wr_din     <= '0;
            rd_addr    <= '0;
            err_wr_cnt <= '0;
            err_rd_cnt <= '0;
        end else begin
            wr_we <= lb_wren ? w_wr_onehot : '0;
            if (lb_wren) begin
                wr_addr <= w_wr_addr_nxt;
                wr_din  <= {NWR{lb_wdata}};
            end
            if (lb_rden)
                rd_addr <= w_rd_addr_nxt;
            err_wr_cnt <= err_next(err_wr_cnt, lb_wren & ~|w_wr_hit, err_clr);
            err_rd_cnt <= err_next(err_rd_cnt, lb_rden & w_rd_unmap, err_clr);
        end
    end

    // Stage p0 is visible with rd_addr; stage READDELAY lines up with valid rd_dout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_vld_p <= '0;
        else
            r_vld_p <= {r_vld_p[NST-2:0], lb_rden};
    end

    always_ff @(posedge clk) begin
        r_last_p   <= {r_last_p[NST-2:0], lb_rdenlast};
        r_unmap_p  <= {r_unmap_p[NST-2:0], w_rd_unmap};
        r_sel_p[0] <= w_rd_sel;
        for (int i = 1; i < NST; i++)
            r_sel_p[i] <= r_sel_p[i-1];
        if (r_vld_p[READDELAY])
            r_rdat_p <= w_rd_dout_arr[r_sel_p[READDELAY]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lb_rdata      <= '0;
            lb_rvalid     <= 1'b0;
            lb_rvalidlast <= 1'b0;
        end else begin
            lb_rvalid     <= r_vld_p[NST-1];
            lb_rvalidlast <= r_vld_p[NST-1] & r_last_p[NST-1];
            if (r_vld_p[NST-1])
                lb_rdata <= r_unmap_p[NST-1] ? DEFAULT_RDATA : r_rdat_p;
        end
    end

endmodule

// File: tb/tb_lb_bram_bridge.sv
// Scoreboarded bench for lb_bram_bridge: directed writes, bursts, unmapped accesses,
// counter saturation/clear, overlapping windows and reset in the middle of a read.
module tb_lb_bram_bridge;

    localparam int L    = 7;
    localparam int RDLY = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          lb_wren = 1'b0;
    logic [23:0]   lb_waddr = '0;
    logic [31:0]   lb_wdata = '0;
    logic          lb_rden = 1'b0;
    logic [23:0]   lb_raddr = '0;
    logic          lb_rdenlast = 1'b0;
    logic          err_clr = 1'b0;
    logic [127:0]  rd_dout;

    logic [31:0]   lb_rdata;
    logic          lb_rvalid, lb_rvalidlast;
    logic [3:0]    wr_we;
    logic [63:0]   wr_addr, rd_addr;
    logic [127:0]  wr_din;
    logic [15:0]   err_wr_cnt, err_rd_cnt;

    logic [31:0]   ovl_rdata;
    logic          ovl_rvalid, ovl_rvalidlast;
    logic [3:0]    ovl_wr_we;
    logic [63:0]   ovl_wr_addr, ovl_rd_addr;
    logic [127:0]  ovl_wr_din;
    logic [15:0]   ovl_err_wr, ovl_err_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct { int cyc; logic [31:0] data; bit last; } rd_e_t;
    typedef struct { int cyc; logic [3:0] we; logic [63:0] addr; logic [127:0] din; } wr_e_t;
    rd_e_t rdq[$];
    wr_e_t wrq[$];

    lb_bram_bridge u_dut (
        .clk(clk), .rstn(rstn),
        .lb_wren(lb_wren), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .lb_rden(lb_rden), .lb_raddr(lb_raddr), .lb_rdenlast(lb_rdenlast),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .lb_rvalidlast(lb_rvalidlast),
        .wr_we(wr_we), .wr_addr(wr_addr), .wr_din(wr_din),
        .rd_addr(rd_addr), .rd_dout(rd_dout),
        .err_clr(err_clr), .err_wr_cnt(err_wr_cnt), .err_rd_cnt(err_rd_cnt)
    );

    lb_bram_bridge #(
        .WR_BASE({24'h030000, 24'h020000, 24'h000000, 24'h000000}),
        .WR_AW  ({8'd16, 8'd16, 8'd12, 8'd16})
    ) u_ovl (
        .clk(clk), .rstn(rstn),
        .lb_wren(lb_wren), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .lb_rden(lb_rden), .lb_raddr(lb_raddr), .lb_rdenlast(lb_rdenlast),
        .lb_rdata(ovl_rdata), .lb_rvalid(ovl_rvalid), .lb_rvalidlast(ovl_rvalidlast),
        .wr_we(ovl_wr_we), .wr_addr(ovl_wr_addr), .wr_din(ovl_wr_din),
        .rd_addr(ovl_rd_addr), .rd_dout(rd_dout),
        .err_clr(err_clr), .err_wr_cnt(ovl_err_wr), .err_rd_cnt(ovl_err_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wr_aw(int k);
        return 16;
    endfunction
    function automatic logic [23:0] wr_base(int k);
        return 24'(k) << 16;
    endfunction
    function automatic int rd_aw(int k);
        return (k < 2) ? 14 : 12;
    endfunction
    function automatic logic [23:0] rd_base(int k);
        case (k)
            0:       return 24'h040000;
            1:       return 24'h044000;
            2:       return 24'h080000;
            default: return 24'h081000;
        endcase
    endfunction
    function automatic logic [23:0] lmask(int aw);
        return (24'd1 << aw) - 24'd1;
    endfunction
    function automatic int wr_ch(logic [23:0] a);
        for (int k = 0; k < 4; k++)
            if ((a >> wr_aw(k)) == (wr_base(k) >> wr_aw(k))) return k;
        return -1;
    endfunction
    function automatic int rd_ch(logic [23:0] a);
        for (int k = 0; k < 4; k++)
            if ((a >> rd_aw(k)) == (rd_base(k) >> rd_aw(k))) return k;
        return -1;
    endfunction
    // BRAM content model: low 16 bits of the channel base plus word offset plus 0x100.
    function automatic logic [31:0] bram_word(int k, logic [15:0] off);
        return 32'(rd_base(k) & 24'h00FFFF) + 32'(off) + 32'h100;
    endfunction
    function automatic logic [31:0] exp_rdata(logic [23:0] a);
        int ch = rd_ch(a);
        if (ch < 0) return 32'hDEADBEEF;
        return bram_word(ch, 16'(a & lmask(rd_aw(ch))));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // BRAM model: READDELAY cycles from rd_addr to rd_dout.
    logic [31:0] bm [4][RDLY];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            bm[k][0] <= bram_word(k, rd_addr[k*16 +: 16]);
            for (int i = 1; i < RDLY; i++) bm[k][i] <= bm[k][i-1];
        end
    end
    always_comb begin
        rd_dout = '0;
        for (int k = 0; k < 4; k++) rd_dout[k*32 +: 32] = bm[k][RDLY-1];
    end

    // Reference error counters.
    logic [15:0] m_ew, m_er;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ew <= '0;
            m_er <= '0;
        end else begin
            if (err_clr) begin
                m_ew <= {15'd0, lb_wren && wr_ch(lb_waddr) < 0};
                m_er <= {15'd0, lb_rden && rd_ch(lb_raddr) < 0};
            end else begin
                if (lb_wren && wr_ch(lb_waddr) < 0 && m_ew != 16'hFFFF) m_ew <= m_ew + 16'd1;
                if (lb_rden && rd_ch(lb_raddr) < 0 && m_er != 16'hFFFF) m_er <= m_er + 16'd1;
            end
        end
    end

    rd_e_t       mr;
    wr_e_t       mw;
    bit          ev;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_rdata", lb_rdata, 0);
            chk("rst_rvalid", {lb_rvalid, lb_rvalidlast}, 0);
            chk("rst_wr_we", wr_we, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_din", wr_din, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_err", {err_wr_cnt, err_rd_cnt}, 0);
            m_rdata = '0;
        end else begin
            ev = (rdq.size() > 0) && (rdq[0].cyc == cyc);
            chk("rvalid", lb_rvalid, ev);
            if (ev) begin
                mr = rdq.pop_front();
                chk("rdata", lb_rdata, mr.data);
                chk("rvalidlast", lb_rvalidlast, mr.last);
                m_rdata = mr.data;
            end else begin
                chk("rvalidlast_idle", lb_rvalidlast, 0);
                chk("rdata_hold", lb_rdata, m_rdata);
            end
            ev = (wrq.size() > 0) && (wrq[0].cyc == cyc);
            if (ev) begin
                mw = wrq.pop_front();
                chk("wr_we", wr_we, mw.we);
                chk("wr_addr", wr_addr, mw.addr);
                chk("wr_din", wr_din, mw.din);
            end else begin
                chk("wr_we_idle", wr_we, 0);
            end
            chk("err_wr_cnt", err_wr_cnt, m_ew);
            chk("err_rd_cnt", err_rd_cnt, m_er);
        end
    end

    task automatic drv(input bit we, input logic [23:0] wa, input logic [31:0] wd,
                       input bit re, input logic [23:0] ra, input bit last, input bit clr);
        rd_e_t r;
        wr_e_t w;
        int    ch;
        @(posedge clk);
        #1;
        lb_wren = we; lb_waddr = wa; lb_wdata = wd;
        lb_rden = re; lb_raddr = ra; lb_rdenlast = last;
        err_clr = clr;
        if (we) begin
            ch     = wr_ch(wa);
            w.cyc  = cyc + 1;
            w.we   = (ch < 0) ? 4'b0000 : 4'(1 << ch);
            for (int k = 0; k < 4; k++) w.addr[k*16 +: 16] = 16'(wa & lmask(wr_aw(k)));
            w.din  = {4{wd}};
            wrq.push_back(w);
        end
        if (re) begin
            r.cyc  = cyc + L;
            r.data = exp_rdata(ra);
            r.last = last;
            rdq.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, '0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(2);

        drv(1, 24'h020005, 32'h12345678, 0, '0, 0, 0);
        idle(2);
        drv(1, 24'h000010, 32'hA5A5_0001, 0, '0, 0, 0);
        drv(1, 24'h010FFF, 32'hA5A5_0002, 0, '0, 0, 0);
        drv(1, 24'h03ABCD, 32'hA5A5_0003, 0, '0, 0, 0);
        idle(2);

        drv(1, 24'h000010, 32'h0BAD_F00D, 0, '0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("ovl_wr_we", ovl_wr_we, 4'b0001);
        idle(2);

        for (int i = 0; i < 4; i++)
            drv(0, '0, '0, 1, 24'h081000 + 24'(i), i == 3, 0);
        idle(12);

        drv(0, '0, '0, 1, 24'h040000, 1, 0);
        drv(0, '0, '0, 1, 24'h043FFF, 0, 0);
        drv(0, '0, '0, 1, 24'h044123, 1, 0);
        drv(1, 24'h031234, 32'hCAFE_0004, 1, 24'h080FFF, 0, 0);
        idle(12);

        drv(1, 24'h0FFFFF, 32'h1111_2222, 1, 24'h0FFFFF, 1, 0);
        idle(1);
        @(negedge clk);
        chk("unmapped_err_rd", err_rd_cnt, 16'd1);
        chk("unmapped_err_wr", err_wr_cnt, 16'd1);
        idle(10);

        drv(0, '0, '0, 0, '0, 0, 1);
        for (int i = 0; i < 65537; i++) drv(0, '0, '0, 1, 24'h0FFFFF, 0, 0);
        idle(1);
        @(negedge clk);
        chk("err_rd_sat", err_rd_cnt, 16'hFFFF);
        drv(0, '0, '0, 1, 24'h0FFFFF, 0, 1);
        idle(1);
        @(negedge clk);
        chk("err_clr_with_event", err_rd_cnt, 16'd1);
        idle(10);

        drv(0, '0, '0, 1, 24'h081002, 1, 0);
        idle(2);
        @(posedge clk);
        #1 rstn = 1'b0;
        rdq.delete();
        wrq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(15);

        drv(0, '0, '0, 1, 24'h044001, 1, 0);
        idle(10);

        chk("rdq_drained", 128'(rdq.size()), 0);
        chk("wrq_drained", 128'(wrq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
